madd_pipe: RTL

Parametrised, fully pipelined multiply-add/multiply-accumulate unit; successor to the single-stage 32-bit `MADD`. It adds configurable width and latency, signed/unsigned operation, a per-operation opcode with an internal accumulator, valid/ready flow control and an overflow flag. It sits in the functional unit wherever `MADD` sat and is fed one operation per cycle by the issue logic.

---
 rtl/madd_pkg.sv | 13 +
 rtl/madd_mult_pipe.sv | 84 ++++++++
 rtl/madd_pipe.sv | 110 +++++++++++
 3 files changed

// File: rtl/madd_pkg.sv
// Shared opcode encoding for the pipelined multiply-add unit.
package madd_pkg;

   localparam int unsigned OP_W = 2;

   typedef enum logic [OP_W-1:0] {
      OP_MADD = 2'b00,
      OP_MAC  = 2'b01,
      OP_LOAD = 2'b10,
      OP_MUL  = 2'b11
   } op_t;

endpackage

// File: rtl/madd_mult_pipe.sv
// Pipelined signed/unsigned multiplier: stage 1 registers extended operands,
// later stages register the 2*WIDTH-bit product; side data travels alongside.
module madd_mult_pipe #(
   parameter int unsigned WIDTH  = 32,
   parameter int unsigned NSTAGE = 2,
   parameter int unsigned SIDE_W = 1
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 en_i,
   input  logic                 valid_i,
   input  logic                 signed_i,
   input  logic [WIDTH-1:0]     a_i,
   input  logic [WIDTH-1:0]     b_i,
   input  logic [SIDE_W-1:0]    side_i,
   output logic                 valid_o,
   output logic [2*WIDTH-1:0]   prod_o,
   output logic [SIDE_W-1:0]    side_o
);

   localparam int unsigned PW = 2 * WIDTH;

   logic              v1_q;
   logic [PW-1:0]     a_q;
   logic [PW-1:0]     b_q;
   logic [SIDE_W-1:0] side1_q;
   logic [PW-1:0]     prod_c;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         v1_q <= 1'b0;
      end else if (en_i) begin
         v1_q <= valid_i;
      end
   end

   // Extending to 2*WIDTH makes a truncated 2*WIDTH product exact for both signednesses
   always_ff @(posedge clk_i) begin
      if (en_i) begin
         a_q     <= {{WIDTH{signed_i & a_i[WIDTH-1]}}, a_i};
         b_q     <= {{WIDTH{signed_i & b_i[WIDTH-1]}}, b_i};
         side1_q <= side_i;
      end
   end

   assign prod_c = a_q * b_q;

   if (NSTAGE == 1) begin : g_comb
      assign valid_o = v1_q;
      assign prod_o  = prod_c;
      assign side_o  = side1_q;
   end else begin : g_reg
      logic [NSTAGE-2:0] v_q;
      logic [PW-1:0]     p_q [NSTAGE-1];
      logic [SIDE_W-1:0] s_q [NSTAGE-1];

      always_ff @(posedge clk_i) begin
         if (rst_i) begin
            v_q <= '0;
         end else if (en_i) begin
            v_q[0] <= v1_q;
            for (int k = 1; k < int'(NSTAGE) - 1; k++) begin
               v_q[k] <= v_q[k-1];
            end
         end
      end

      always_ff @(posedge clk_i) begin
         if (en_i) begin
            p_q[0] <= prod_c;
            s_q[0] <= side1_q;
            for (int k = 1; k < int'(NSTAGE) - 1; k++) begin
               p_q[k] <= p_q[k-1];
               s_q[k] <= s_q[k-1];
            end
         end
      end

      assign valid_o = v_q[NSTAGE-2];
      assign prod_o  = p_q[NSTAGE-2];
      assign side_o  = s_q[NSTAGE-2];
   end

endmodule

// File: rtl/madd_pipe.sv
// Pipelined multiply-add/accumulate with valid/ready flow control; the final
// stage picks the addend, updates the accumulator and flags overflow.
module madd_pipe
   import madd_pkg::*;
#(
   parameter int unsigned WIDTH  = 32,
   parameter int unsigned STAGES = 3
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              IN_VALID,
   output logic              IN_READY,
   input  logic [WIDTH-1:0]  A,
   input  logic [WIDTH-1:0]  B,
   input  logic [WIDTH-1:0]  C,
   input  logic [OP_W-1:0]   OP,
   input  logic              SIGNED,
   output logic              OUT_VALID,
   input  logic              OUT_READY,
   output logic [WIDTH-1:0]  Z,
   output logic              OVF
);

   localparam int unsigned PW     = 2 * WIDTH;
   localparam int unsigned SW     = PW + 1;
   localparam int unsigned SIDE_W = OP_W + 1 + WIDTH;

   logic              adv_c;
   logic              m_valid;
   logic [PW-1:0]     m_prod;
   logic [SIDE_W-1:0] m_side;

   op_t               m_op;
   logic              m_signed;
   logic [WIDTH-1:0]  addend_c;
   logic [SW-1:0]     sum_c;
   logic              ovf_c;
   logic              acc_wr_c;

   logic              out_valid_q;
   logic [WIDTH-1:0]  z_q;
   logic              ovf_q;
   logic [WIDTH-1:0]  acc_q;

   // One global stall: nothing moves while a result waits on the consumer
   assign adv_c    = !out_valid_q || OUT_READY;
   assign IN_READY = adv_c;

   madd_mult_pipe #(
      .WIDTH  (WIDTH),
      .NSTAGE (STAGES - 1),
      .SIDE_W (SIDE_W)
   ) u_mult (
      .clk_i    (CLK),
      .rst_i    (RST),
      .en_i     (adv_c),
      .valid_i  (IN_VALID),
      .signed_i (SIGNED),
      .a_i      (A),
      .b_i      (B),
      .side_i   ({OP, SIGNED, C}),
      .valid_o  (m_valid),
      .prod_o   (m_prod),
      .side_o   (m_side)
   );

   // Addend selection and exact (2*WIDTH+1)-bit sum for the overflow check
   always_comb begin
      m_op     = op_t'(m_side[SIDE_W-1 -: OP_W]);
      m_signed = m_side[WIDTH];
      addend_c = '0;
      ovf_c    = 1'b0;
      unique case (m_op)
         OP_MADD, OP_LOAD: addend_c = m_side[WIDTH-1:0];
         OP_MAC:           addend_c = acc_q;
         default:          addend_c = '0;
      endcase
      sum_c = {m_signed & m_prod[PW-1], m_prod}
            + {{(SW-WIDTH){m_signed & addend_c[WIDTH-1]}}, addend_c};
      if (m_signed) begin
         ovf_c = (sum_c[SW-1:WIDTH-1] != '0) && (sum_c[SW-1:WIDTH-1] != '1);
      end else begin
         ovf_c = |sum_c[SW-1:WIDTH];
      end
      acc_wr_c = m_valid && ((m_op == OP_MAC) || (m_op == OP_LOAD));
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         out_valid_q <= 1'b0;
         z_q         <= '0;
         ovf_q       <= 1'b0;
         acc_q       <= '0;
      end else if (adv_c) begin
         out_valid_q <= m_valid;
         if (m_valid) begin
            z_q   <= sum_c[WIDTH-1:0];
            ovf_q <= ovf_c;
         end
         if (acc_wr_c) begin
            acc_q <= sum_c[WIDTH-1:0];
         end
      end
   end

   assign OUT_VALID = out_valid_q;
   assign Z         = z_q;
   assign OVF       = ovf_q;

endmodule
